// File: rtl/brq_dccm_arbiter_pkg.sv
// Shared types for the DCCM arbiter.
//   arb_state_e : owner of the previous beat (IDLE/CORE/DMA)
//   rd_tag_t    : registered read-return tag {valid, owner}
//   OWNER_*     : owner encoding used inside rd_tag_t
package brq_dccm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DMA  = 2'd2
  } arb_state_e;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DMA  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/brq_dccm_arbiter_if.sv
// Bus bundle between the core port (c_*), the DMA port (d_*) and the DCCM (m_*).
//   slave  : arbiter view (requests and m_rdata in; grants, read return, DCCM strobes out)
//   master : environment view (requesters and DCCM), directions mirrored
interface brq_dccm_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
);

  logic                 c_req;
  logic                 c_we;
  logic [2:0]           c_be;
  logic [AddrWidth-1:0] c_addr;
  logic [DataWidth-1:0] c_wdata;
  logic                 c_gnt;
  logic                 c_rvalid;
  logic [DataWidth-1:0] c_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [2:0]           d_be;
  logic [AddrWidth-1:0] d_addr;
  logic [DataWidth-1:0] d_wdata;
  logic                 d_lock;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [DataWidth-1:0] d_rdata;

  logic                 m_read_en;
  logic                 m_write_en;
  logic [2:0]           m_byte_en;
  logic [AddrWidth-1:0] m_addr;
  logic [DataWidth-1:0] m_wdata;
  logic [DataWidth-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output m_read_en, m_write_en, m_byte_en, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_read_en, m_write_en, m_byte_en, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/brq_dccm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, clr   : count up by one / return to zero
//   at_max     : count has reached Max
module brq_sat_counter #(
  parameter int Width = 4,
  parameter int Max   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [Width-1:0] count;

  assign at_max = (count == Width'(Max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/brq_dccm_arbiter.sv
// Two-port arbiter for the single-port DCCM: core (P0) has priority, DMA (P1)
// is protected by a starvation counter and may hold ownership with d_lock for a
// bounded burst. One grant per cycle; read data (1-cycle DCCM latency) is routed
// back only to the port that issued the read.
//   brq_clk, brq_rst : clock, asynchronous active-low reset
//   bus              : brq_dccm_arbiter_if.slave (c_*, d_*, m_* signals)
// Optional build macro BRQ_DCCM_ARB_PERF_EN adds perf_clr input and the 32-bit
// perf_c_grants / perf_d_grants / perf_conflicts counters.
module brq_dccm_arbiter
  import brq_dccm_arb_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 15,
  parameter int StarveLimit = 8,
  parameter int MaxBurst    = 4
) (
  input  logic                     brq_clk,
  input  logic                     brq_rst,
  brq_dccm_arbiter_if.slave        bus
`ifdef BRQ_DCCM_ARB_PERF_EN
  ,
  input  logic                     perf_clr,
  output logic [31:0]              perf_c_grants,
  output logic [31:0]              perf_d_grants,
  output logic [31:0]              perf_conflicts
`endif
);

  localparam int StarveW = $clog2(StarveLimit + 1);
  localparam int BurstW  = $clog2(MaxBurst + 1);

  arb_state_e state, state_nxt;
  logic       c_win, d_win;
  logic       starve_max, burst_max;
  rd_tag_t    rd_tag_nxt, rd_tag_p1;

  // Grant decision and next owner. burst_cnt < MaxBurst is !burst_max since
  // the burst counter saturates at MaxBurst.
  always_comb begin
    c_win     = 1'b0;
    d_win     = 1'b0;
    state_nxt = IDLE;
    if (bus.c_req && bus.d_req) begin
      if (starve_max || (state == DMA && bus.d_lock && !burst_max)) begin
        d_win = 1'b1;
      end else begin
        c_win = 1'b1;
      end
    end else begin
      c_win = bus.c_req;
      d_win = bus.d_req;
    end
    if (c_win) begin
      state_nxt = CORE;
    end else if (d_win) begin
      state_nxt = DMA;
    end
  end

  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign bus.c_gnt = c_win;
  assign bus.d_gnt = d_win;

  brq_sat_counter #(.Width(StarveW), .Max(StarveLimit)) u_starve (
    .clk    (brq_clk),
    .rst_n  (brq_rst),
    .inc    (bus.d_req && !d_win),
    .clr    (!bus.d_req || d_win),
    .at_max (starve_max)
  );

  brq_sat_counter #(.Width(BurstW), .Max(MaxBurst)) u_burst (
    .clk    (brq_clk),
    .rst_n  (brq_rst),
    .inc    (d_win),
    .clr    (!d_win),
    .at_max (burst_max)
  );

  // Memory side: straight from the winner's inputs, all zero without a grant.
  always_comb begin
    bus.m_read_en  = 1'b0;
    bus.m_write_en = 1'b0;
    bus.m_byte_en  = '0;
    bus.m_addr     = '0;
    bus.m_wdata    = '0;
    if (c_win) begin
      bus.m_read_en  = !bus.c_we;
      bus.m_write_en = bus.c_we;
      bus.m_byte_en  = bus.c_be;
      bus.m_addr     = bus.c_addr;
      bus.m_wdata    = bus.c_wdata;
    end else if (d_win) begin
      bus.m_read_en  = !bus.d_we;
      bus.m_write_en = bus.d_we;
      bus.m_byte_en  = bus.d_be;
      bus.m_addr     = bus.d_addr;
      bus.m_wdata    = bus.d_wdata;
    end
  end

  always_comb begin
    rd_tag_nxt.valid = bus.m_read_en;
    rd_tag_nxt.owner = d_win ? OWNER_DMA : OWNER_CORE;
  end

  // Stage p0 -> p1: the DCCM registers read data; the tag follows it one cycle.
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      rd_tag_p1 <= '0;
    end else begin
      rd_tag_p1 <= rd_tag_nxt;
    end
  end

  assign bus.c_rvalid = rd_tag_p1.valid && (rd_tag_p1.owner == OWNER_CORE);
  assign bus.d_rvalid = rd_tag_p1.valid && (rd_tag_p1.owner == OWNER_DMA);
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

`ifdef BRQ_DCCM_ARB_PERF_EN
  always_ff @(posedge brq_clk or negedge brq_rst) begin
    if (!brq_rst) begin
      perf_c_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (perf_clr) begin
      perf_c_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (c_win)                   perf_c_grants  <= perf_c_grants + 32'd1;
      if (d_win)                   perf_d_grants  <= perf_d_grants + 32'd1;
      if (bus.c_req && bus.d_req)  perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_brq_dccm_arbiter.sv
// Directed bench for brq_dccm_arbiter: reset state, single-port read return,
// starvation release, DMA burst lock, reset during a read, write/read
// alternation through a small DCCM model, and (with BRQ_DCCM_ARB_PERF_EN)
// the performance counters.
module tb_brq_dccm_arbiter;

  localparam int         DW      = 32;
  localparam int         AW      = 15;
  localparam logic [2:0] BE_WORD = 3'b010;

  logic brq_clk = 1'b0;
  logic brq_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 brq_clk = ~brq_clk;

  brq_dccm_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

`ifdef BRQ_DCCM_ARB_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_c_grants, perf_d_grants, perf_conflicts;
`endif

  brq_dccm_arbiter #(
    .DataWidth(DW), .AddrWidth(AW), .StarveLimit(8), .MaxBurst(4)
  ) dut (
    .brq_clk (brq_clk),
    .brq_rst (brq_rst),
    .bus     (bus.slave)
`ifdef BRQ_DCCM_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_c_grants  (perf_c_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  // DCCM model: registered read, 1-cycle latency, preloaded while in reset.
  logic [31:0] mem [0:255];
  always @(posedge brq_clk) begin
    if (!brq_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10]  <= 32'hA5A5_1234;
      bus.m_rdata <= '0;
    end else begin
      if (bus.m_write_en) mem[bus.m_addr[7:0]] <= bus.m_wdata;
      if (bus.m_read_en)  bus.m_rdata <= mem[bus.m_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_be = '0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_lock = 1'b0;
  endtask

  logic [31:0] wvals [2];
  logic        exp_d;

  initial begin
    wvals[0] = 32'hDEAD_BEEF;
    wvals[1] = 32'h0BAD_F00D;
    brq_rst = 1'b0;
    idle_inputs();
`ifdef BRQ_DCCM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    // Reset state
    #1;
    check("rst_c_gnt",    bus.c_gnt, 0);
    check("rst_d_gnt",    bus.d_gnt, 0);
    check("rst_c_rvalid", bus.c_rvalid, 0);
    check("rst_d_rvalid", bus.d_rvalid, 0);
    check("rst_c_rdata",  bus.c_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata, 0);
    check("rst_m_rd",     bus.m_read_en, 0);
    check("rst_m_wr",     bus.m_write_en, 0);
    check("rst_m_addr",   bus.m_addr, 0);
    check("rst_state",    dut.state, 0);
    @(posedge brq_clk);
    next();
    brq_rst = 1'b1;

    // Core-only read of 0x10
    bus.c_req = 1'b1; bus.c_addr = 15'h10; bus.c_be = BE_WORD;
    #1;
    check("rd_c_gnt",  bus.c_gnt, 1);
    check("rd_d_gnt",  bus.d_gnt, 0);
    check("rd_m_rd",   bus.m_read_en, 1);
    check("rd_m_wr",   bus.m_write_en, 0);
    check("rd_m_addr", bus.m_addr, 15'h10);
    check("rd_m_be",   bus.m_byte_en, BE_WORD);
    next();
    idle_inputs();
    #1;
    check("rd_c_rvalid", bus.c_rvalid, 1);
    check("rd_c_rdata",  bus.c_rdata, 32'hA5A5_1234);
    check("rd_d_rvalid", bus.d_rvalid, 0);
    check("rd_d_rdata",  bus.d_rdata, 0);
    next();
    #1;
    check("rd_c_rvalid_off", bus.c_rvalid, 0);
    check("rd_c_rdata_off",  bus.c_rdata, 0);

    // Both requesting continuously: 8 core grants, then DMA, repeating
    next();
    bus.c_req = 1'b1; bus.c_addr = 15'h1;
    bus.d_req = 1'b1; bus.d_addr = 15'h2;
    for (int i = 0; i < 18; i++) begin
      #1;
      exp_d = (i == 8) || (i == 17);
      check($sformatf("starve_c_gnt_%0d", i), bus.c_gnt, !exp_d);
      check($sformatf("starve_d_gnt_%0d", i), bus.d_gnt, exp_d);
      check($sformatf("starve_m_addr_%0d", i), bus.m_addr, exp_d ? 15'h2 : 15'h1);
      next();
    end
    idle_inputs();
    next();

    // DMA burst lock: 4 consecutive DMA beats, then core
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 15'h3;
    #1;
    check("lock_first_d_gnt", bus.d_gnt, 1);
    next();
    bus.c_req = 1'b1; bus.c_addr = 15'h4;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_d = (i < 3);
      check($sformatf("lock_d_gnt_%0d", i), bus.d_gnt, exp_d);
      check($sformatf("lock_c_gnt_%0d", i), bus.c_gnt, !exp_d);
      next();
    end
    #1;
    check("lock_after_core_c_gnt", bus.c_gnt, 1);
    next();
    idle_inputs();
    next();
    bus.d_req = 1'b1;
    #1;
    check("nolock_d_gnt", bus.d_gnt, 1);
    next();
    bus.c_req = 1'b1;
    #1;
    check("nolock_c_gnt", bus.c_gnt, 1);
    check("nolock_d_gnt2", bus.d_gnt, 0);
    next();
    idle_inputs();
    next();

    // Reset while a DMA read is in flight
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 15'h30;
    #1;
    check("rr_d_gnt_a", bus.d_gnt, 1);
    next();
    #1;
    check("rr_d_gnt_b",   bus.d_gnt, 1);
    check("rr_d_rvalid_a", bus.d_rvalid, 1);
    #2;
    brq_rst = 1'b0;
    idle_inputs();
    #1;
    check("rr_d_rvalid_rst", bus.d_rvalid, 0);
    check("rr_d_rdata_rst",  bus.d_rdata, 0);
    check("rr_state",        dut.state, 0);
    check("rr_burst",        dut.u_burst.count, 0);
    check("rr_starve",       dut.u_starve.count, 0);
    check("rr_d_gnt_rst",    bus.d_gnt, 0);
    next();
    check("rr_d_rvalid_hold", bus.d_rvalid, 0);
    check("rr_c_rvalid_hold", bus.c_rvalid, 0);
    brq_rst = 1'b1;
    bus.c_req = 1'b1; bus.d_req = 1'b1;
    #1;
    check("rr_restart_c_gnt", bus.c_gnt, 1);
    check("rr_restart_d_gnt", bus.d_gnt, 0);
    next();
    idle_inputs();
    #1;
    check("rr_restart_c_rvalid", bus.c_rvalid, 1);
    check("rr_restart_d_rvalid", bus.d_rvalid, 0);
    next();

    // Core write then DMA read of 0x20, twice
    for (int k = 0; k < 2; k++) begin
      bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 15'h20;
      bus.c_wdata = wvals[k]; bus.c_be = BE_WORD;
      #1;
      check($sformatf("wr_c_gnt_%0d", k),  bus.c_gnt, 1);
      check($sformatf("wr_m_wr_%0d", k),   bus.m_write_en, 1);
      check($sformatf("wr_m_rd_%0d", k),   bus.m_read_en, 0);
      check($sformatf("wr_m_wdata_%0d", k), bus.m_wdata, wvals[k]);
      check($sformatf("wr_m_be_%0d", k),   bus.m_byte_en, BE_WORD);
      next();
      idle_inputs();
      bus.d_req = 1'b1; bus.d_addr = 15'h20;
      #1;
      check($sformatf("wr_c_rvalid_a_%0d", k), bus.c_rvalid, 0);
      check($sformatf("rd_d_gnt_%0d", k),      bus.d_gnt, 1);
      check($sformatf("rd_m_rd_%0d", k),       bus.m_read_en, 1);
      next();
      idle_inputs();
      #1;
      check($sformatf("rd_d_rvalid_%0d", k), bus.d_rvalid, 1);
      check($sformatf("rd_d_rdata_%0d", k),  bus.d_rdata, wvals[k]);
      check($sformatf("rd_c_rvalid_%0d", k), bus.c_rvalid, 0);
      check($sformatf("rd_c_rdata_%0d", k),  bus.c_rdata, 0);
      next();
    end

`ifdef BRQ_DCCM_ARB_PERF_EN
    // Performance counters: 10 conflict cycles, then clear with both requesting
    perf_clr = 1'b1;
    next();
    perf_clr = 1'b0;
    #1;
    check("perf_clr_idle", perf_conflicts, 0);
    bus.c_req = 1'b1; bus.d_req = 1'b1;
    for (int i = 0; i < 10; i++) next();
    check("perf_conflicts_10", perf_conflicts, 10);
    check("perf_c_grants_9",   perf_c_grants, 9);
    check("perf_d_grants_1",   perf_d_grants, 1);
    perf_clr = 1'b1;
    next();
    perf_clr = 1'b0;
    idle_inputs();
    #1;
    check("perf_conflicts_clr", perf_conflicts, 0);
    check("perf_c_grants_clr",  perf_c_grants, 0);
    check("perf_d_grants_clr",  perf_d_grants, 0);
    next();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
